// File: rtl/vga_ctrl_pkg.sv
// Shared types and defaults for the VGA filter-mode controller.
package vga_ctrl_pkg;

   typedef enum logic [1:0] {MODE_COLOR, MODE_GRAY, MODE_INVERT, MODE_MONO} filter_mode_e;

   typedef enum logic {S_RUN, S_PEND} mode_state_e;

   localparam int unsigned DEF_NUM_MODES    = 4;
   localparam int unsigned DEF_DEBOUNCE_CYC = 250000;  // 10 ms at 25 MHz
   localparam int unsigned DEF_AUTO_FRAMES  = 120;

   // Next value of a counter that wraps modulus-1 -> 0.
   function automatic int unsigned wrap_inc(input int unsigned val, input int unsigned modulus);
      return (val >= modulus - 1) ? 0 : val + 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and rising-edge pulse.
module btn_debounce
   import vga_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_req
);

   localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   logic [1:0]    r_sync;
   logic          r_db;
   logic [CW-1:0] r_cnt;
   logic          r_req;
   logic          w_differs;
   logic          w_accept;

   // Bring the raw button into the clock domain.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], i_btn};
      end
   end

   // A level differing from the debounced one is accepted after DEBOUNCE_CYC straight cycles.
   always_comb begin
      w_differs = r_sync[1] ^ r_db;
      w_accept  = w_differs && (r_cnt == CW'(DEBOUNCE_CYC - 1));
   end

   // Stability counter, debounced level and one-cycle pulse on an accepted press.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
         r_db  <= 1'b0;
         r_req <= 1'b0;
      end else begin
         r_req <= w_accept & r_sync[1];
         if (w_accept) begin
            r_db  <= r_sync[1];
            r_cnt <= '0;
         end else if (w_differs) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            // Synced level went back to the debounced one: restart the stability window.
            r_cnt <= '0;
         end
      end
   end

   assign o_req = r_req;

endmodule

// File: rtl/vga_filter_mode_ctrl.sv
// Filter-mode sequencer: button/slideshow requests committed only at the v_sync falling edge.
module vga_filter_mode_ctrl
   import vga_ctrl_pkg::*;
#(
   parameter int unsigned NUM_MODES    = DEF_NUM_MODES,
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned AUTO_FRAMES  = DEF_AUTO_FRAMES,
   localparam int unsigned MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_btn_next,
   input  logic          i_auto_en,
   input  logic          i_v_sync,
   output logic [MW-1:0] o_mode_sel,
   output logic          o_mode_pending,
   output logic          o_frame_tick,
   output logic [15:0]   o_frame_cnt
);

   localparam int unsigned AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

   logic          w_req_btn;
   logic          r_vs_d;
   logic          w_fb;
   logic          r_frame_tick;
   logic [15:0]   r_frame_cnt;
   logic [AW-1:0] r_auto_cnt;
   logic          w_auto_last;
   logic          w_req_auto;
   logic          w_req;
   logic          w_commit;
   mode_state_e   r_state;
   mode_state_e   w_state_next;
   logic [MW-1:0] r_mode_sel;

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_btn_debounce (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_btn   (i_btn_next),
      .o_req   (w_req_btn)
   );

   // Delayed v_sync; resets low so no boundary is seen right after reset.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_vs_d <= 1'b0;
      end else begin
         r_vs_d <= i_v_sync;
      end
   end

   // Frame boundary and request sources.
   always_comb begin
      w_fb        = r_vs_d & ~i_v_sync;
      w_auto_last = (r_auto_cnt == AW'(AUTO_FRAMES - 1));
      w_req_auto  = i_auto_en & w_fb & w_auto_last;
      w_req       = w_req_btn | w_req_auto;
   end

   // Frame tick pulse and free-running frame counter, both one cycle after the boundary.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_frame_tick <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_frame_tick <= w_fb;
         if (w_fb) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   // Slideshow frame counter; held at zero while auto mode is off so enabling restarts it.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_auto_cnt <= '0;
      end else if (!i_auto_en) begin
         r_auto_cnt <= '0;
      end else if (w_fb) begin
         r_auto_cnt <= w_auto_last ? '0 : r_auto_cnt + 1'b1;
      end
   end

   // Next state: a request in S_RUN is queued even on a boundary cycle; S_PEND absorbs requests.
   always_comb begin
      w_state_next = r_state;
      w_commit     = 1'b0;
      unique case (r_state)
         S_RUN: begin
            if (w_req) begin
               w_state_next = S_PEND;
            end
         end
         S_PEND: begin
            if (w_fb) begin
               w_state_next = S_RUN;
               w_commit     = 1'b1;
            end
         end
         default: w_state_next = S_RUN;
      endcase
   end

   // FSM state and committed mode; mode_sel only moves on a boundary edge.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_RUN;
         r_mode_sel <= MW'(MODE_COLOR);
      end else begin
         r_state <= w_state_next;
         if (w_commit) begin
            r_mode_sel <= MW'(wrap_inc(32'(r_mode_sel), NUM_MODES));
         end
      end
   end

   assign o_mode_sel     = r_mode_sel;
   assign o_mode_pending = (r_state == S_PEND);
   assign o_frame_tick   = r_frame_tick;
   assign o_frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_vga_filter_mode_ctrl.sv
// Self-checking bench for vga_filter_mode_ctrl with a frame-level reference model.
module tb_vga_filter_mode_ctrl;

   localparam int unsigned NUM_MODES    = 4;
   localparam int unsigned DEBOUNCE_CYC = 4;
   localparam int unsigned AUTO_FRAMES  = 3;
   localparam int          FRAME_LEN    = 20;
   localparam int          VS_LOW       = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        btn_next;
   logic        auto_en;
   logic        v_sync = 1'b1;
   logic [1:0]  mode_sel;
   logic        mode_pending;
   logic        frame_tick;
   logic [15:0] frame_cnt;

   int checks   = 0;
   int failures = 0;

   // Stimulus-to-model handoff (written only by the main initial block).
   int btn_reqs    = 0;
   bit tb_cnt_load = 1'b0;

   // Reference model state (written only by the model process).
   int unsigned m_mode      = 0;
   int unsigned m_auto      = 0;
   bit          m_pending   = 1'b0;
   bit          m_tick      = 1'b0;
   bit          m_vs_prev   = 1'b0;
   logic [15:0] m_frame_cnt = '0;
   int          m_btn_used  = 0;

   int ph = 0;

   always #5 clk = ~clk;

   vga_filter_mode_ctrl #(
      .NUM_MODES    (NUM_MODES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .AUTO_FRAMES  (AUTO_FRAMES)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_btn_next     (btn_next),
      .i_auto_en      (auto_en),
      .i_v_sync       (v_sync),
      .o_mode_sel     (mode_sel),
      .o_mode_pending (mode_pending),
      .o_frame_tick   (frame_tick),
      .o_frame_cnt    (frame_cnt)
   );

   // v_sync: low for VS_LOW of every FRAME_LEN cycles, driven on the falling clock edge.
   always @(negedge clk) begin
      ph     = (ph + 1) % FRAME_LEN;
      v_sync = (ph < FRAME_LEN - VS_LOW);
   end

   // Frame-level model: one step per frame boundary, at most one mode step per frame.
   always @(posedge clk) begin
      bit commit;
      m_tick = 1'b0;
      if (reset) begin
         m_mode      = 0;
         m_auto      = 0;
         m_pending   = 1'b0;
         m_vs_prev   = 1'b0;
         m_frame_cnt = '0;
         m_btn_used  = btn_reqs;
      end else begin
         if (tb_cnt_load) m_frame_cnt = 16'hFFFF;
         if (m_vs_prev && !v_sync) begin
            m_tick      = 1'b1;
            m_frame_cnt = m_frame_cnt + 16'd1;
            commit      = m_pending;
            if (commit) begin
               m_mode    = (m_mode + 1) % NUM_MODES;
               m_pending = 1'b0;
            end
            if (auto_en) begin
               if (m_auto == AUTO_FRAMES - 1) begin
                  m_auto = 0;
                  if (!commit) m_pending = 1'b1;
               end else begin
                  m_auto = m_auto + 1;
               end
            end
         end
         if (!auto_en) m_auto = 0;
         if (m_btn_used != btn_reqs) begin
            m_btn_used = btn_reqs;
            m_pending  = 1'b1;
         end
         m_vs_prev = v_sync;
      end
   end

   // Advance to just after the next frame-boundary clock edge (bounded).
   task automatic wait_fb();
      for (int n = 0; n < 3 * FRAME_LEN; n++) begin
         @(posedge clk);
         #1;
         if (m_tick) return;
      end
      $display("FAIL wait_fb: no frame boundary within %0d cycles", 3 * FRAME_LEN);
      $fatal(1);
   endtask

   // Hold the button for a number of cycles; report the cycle pending was first seen (-1 if never).
   task automatic press_button(input int hold, output int lat);
      lat = -1;
      @(negedge clk);
      btn_next = 1'b1;
      for (int i = 1; i <= hold; i++) begin
         @(posedge clk);
         #1;
         if (lat < 0 && mode_pending === 1'b1) lat = i;
      end
      @(negedge clk);
      btn_next = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int lat;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (mode_sel !== 2'd0) begin failures++; $display("FAIL por_mode_sel got=%0d want=0", mode_sel); end
      checks++; if (mode_pending !== 1'b0) begin failures++; $display("FAIL por_pending got=%0b want=0", mode_pending); end
      checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL por_tick got=%0b want=0", frame_tick); end
      checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL por_frame_cnt got=%0h want=0", frame_cnt); end
      @(negedge clk);
      reset = 1'b0;
      wait_fb();
      checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL first_fb_tick got=%0b want=1", frame_tick); end
      checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL first_fb_cnt got=%0h want=1", frame_cnt); end
      for (int k = 0; k < 2; k++) begin
         press_button(10, lat);
         btn_reqs++;
         wait_fb();
      end
      checks++; if (mode_sel !== 2'd2) begin failures++; $display("FAIL pre_reset_mode got=%0d want=2", mode_sel); end
      press_button(10, lat);
      btn_reqs++;
      checks++; if (mode_pending !== 1'b1) begin failures++; $display("FAIL pre_reset_pending got=%0b want=1", mode_pending); end
      #3 reset = 1'b1;
      #1;
      checks++; if (mode_sel !== 2'd0) begin failures++; $display("FAIL mid_reset_mode got=%0d want=0", mode_sel); end
      checks++; if (mode_pending !== 1'b0) begin failures++; $display("FAIL mid_reset_pending got=%0b want=0", mode_pending); end
      checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL mid_reset_tick got=%0b want=0", frame_tick); end
      checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL mid_reset_cnt got=%0h want=0", frame_cnt); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_fb();
      checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL post_reset_tick got=%0b want=1", frame_tick); end
      checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL post_reset_cnt got=%0h want=1", frame_cnt); end
      checks++; if (mode_sel !== 2'd0) begin failures++; $display("FAIL dropped_req_mode got=%0d want=0", mode_sel); end
      checks++; if (mode_pending !== 1'b0) begin failures++; $display("FAIL dropped_req_pending got=%0b want=0", mode_pending); end
   endtask

   task automatic test_button_commit();
      int lat;
      int unsigned m0;
      wait_fb();
      m0 = m_mode;
      press_button(10, lat);
      btn_reqs++;
      checks++; if (lat < 4 || lat > 9) begin failures++; $display("FAIL btn_pending_latency got=%0d want=4..9", lat); end
      checks++; if (mode_sel !== 2'(m0)) begin failures++; $display("FAIL btn_mode_held got=%0d want=%0d", mode_sel, m0); end
      wait_fb();
      checks++; if (mode_sel !== 2'((m0 + 1) % NUM_MODES)) begin failures++; $display("FAIL btn_commit_mode got=%0d want=%0d", mode_sel, (m0 + 1) % NUM_MODES); end
      checks++; if (mode_pending !== 1'b0) begin failures++; $display("FAIL btn_commit_pending got=%0b want=0", mode_pending); end
      checks++; if (frame_cnt !== m_frame_cnt) begin failures++; $display("FAIL btn_frame_cnt got=%0h want=%0h", frame_cnt, m_frame_cnt); end
   endtask

   task automatic test_bounce();
      int unsigned m0;
      int   run;
      logic lvl;
      run = 0;
      lvl = 1'b0;
      wait_fb();
      m0 = m_mode;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (run == 0) begin
            lvl = ~lvl;
            run = int'($urandom_range(1, 2));
         end
         btn_next = lvl;
         run--;
         @(posedge clk);
         #1;
         checks++; if (mode_pending !== 1'b0) begin failures++; $display("FAIL bounce_pending cyc=%0d got=%0b want=0", c, mode_pending); end
      end
      @(negedge clk);
      btn_next = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (mode_sel !== 2'(m0)) begin failures++; $display("FAIL bounce_mode got=%0d want=%0d", mode_sel, m0); end
      checks++; if (mode_pending !== 1'b0) begin failures++; $display("FAIL bounce_final_pending got=%0b want=0", mode_pending); end
   endtask

   task automatic test_auto_wrap();
      int unsigned exp_mode;
      do_reset();
      wait_fb();
      repeat (4) @(negedge clk);
      auto_en = 1'b1;
      for (int i = 0; i <= 12; i++) begin
         wait_fb();
         exp_mode = (i / 3) % NUM_MODES;
         checks++; if (mode_sel !== 2'(exp_mode)) begin failures++; $display("FAIL auto_mode fb=%0d got=%0d want=%0d", i, mode_sel, exp_mode); end
         checks++; if (mode_pending !== (i % 3 == 2)) begin failures++; $display("FAIL auto_pending fb=%0d got=%0b want=%0b", i, mode_pending, (i % 3 == 2)); end
         checks++; if (mode_sel !== 2'(m_mode)) begin failures++; $display("FAIL auto_model fb=%0d got=%0d want=%0d", i, mode_sel, m_mode); end
         checks++; if (frame_cnt !== m_frame_cnt) begin failures++; $display("FAIL auto_frame_cnt fb=%0d got=%0h want=%0h", i, frame_cnt, m_frame_cnt); end
      end
      @(negedge clk);
      auto_en = 1'b0;
   endtask

   task automatic test_btn_and_auto();
      int lat;
      do_reset();
      wait_fb();
      repeat (4) @(negedge clk);
      auto_en = 1'b1;
      wait_fb();
      wait_fb();
      // Auto request fires at the next boundary; the button lands earlier in the same frame.
      press_button(10, lat);
      btn_reqs++;
      wait_fb();
      checks++; if (mode_sel !== 2'd1) begin failures++; $display("FAIL dual_req_mode got=%0d want=1", mode_sel); end
      checks++; if (mode_pending !== 1'b0) begin failures++; $display("FAIL dual_req_pending got=%0b want=0", mode_pending); end
      wait_fb();
      checks++; if (mode_sel !== 2'd1) begin failures++; $display("FAIL dual_req_single_step got=%0d want=1", mode_sel); end
      checks++; if (mode_sel !== 2'(m_mode)) begin failures++; $display("FAIL dual_req_model got=%0d want=%0d", mode_sel, m_mode); end
      @(negedge clk);
      auto_en = 1'b0;
   endtask

   task automatic test_fb_request_and_wrap();
      do_reset();
      wait_fb();
      repeat (4) @(negedge clk);
      auto_en = 1'b1;
      wait_fb();
      wait_fb();
      wait_fb();
      checks++; if (mode_pending !== 1'b1) begin failures++; $display("FAIL fb_req_queued got=%0b want=1", mode_pending); end
      checks++; if (mode_sel !== 2'd0) begin failures++; $display("FAIL fb_req_not_committed got=%0d want=0", mode_sel); end
      wait_fb();
      checks++; if (mode_sel !== 2'd1) begin failures++; $display("FAIL fb_req_next_frame got=%0d want=1", mode_sel); end
      @(negedge clk);
      auto_en = 1'b0;
      repeat (3) @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFF;
      tb_cnt_load = 1'b1;
      @(negedge clk);
      tb_cnt_load = 1'b0;
      release dut.r_frame_cnt;
      wait_fb();
      checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL frame_cnt_wrap got=%0h want=0", frame_cnt); end
      checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL wrap_tick got=%0b want=1", frame_tick); end
      wait_fb();
      checks++; if (frame_cnt !== m_frame_cnt) begin failures++; $display("FAIL post_wrap_cnt got=%0h want=%0h", frame_cnt, m_frame_cnt); end
   endtask

   initial begin
      reset    = 1'b1;
      btn_next = 1'b0;
      auto_en  = 1'b0;
      test_reset();
      test_button_commit();
      test_bounce();
      test_auto_wrap();
      test_btn_and_auto();
      test_fb_request_and_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
